// File: rtl/add_pipe.sv
// add_pipe: pipelined add/subtract; WIDTH is split into STAGES chunks with carry rippled stage to stage.
// Defining ADD_PIPE_SAT_EN adds the sat port and saturation of signed-overflow results.
module add_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
`ifdef ADD_PIPE_SAT_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   if (WIDTH % STAGES != 0) begin : g_bad_cfg
      $error("add_pipe: WIDTH must be a multiple of STAGES");
   end

   logic             advance;
   logic             sat_in;

   logic             v_q   [STAGES];
   logic             v_d   [STAGES];
   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] a_d   [STAGES];
   logic [WIDTH-1:0] b_q   [STAGES];
   logic [WIDTH-1:0] b_d   [STAGES];
   logic [WIDTH-1:0] s_q   [STAGES];
   logic [WIDTH-1:0] s_d   [STAGES];
   logic             c_q   [STAGES];
   logic             c_d   [STAGES];
   logic             sat_q [STAGES];
   logic             sat_d [STAGES];

   logic [WIDTH-1:0] cur_a, cur_b, cur_s;
   logic             cur_c, cur_v, cur_sat;
   logic [CHUNK:0]   csum;

   logic [WIDTH-1:0] y_q, y_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

`ifdef ADD_PIPE_SAT_EN
   assign sat_in = sat;
`else
   assign sat_in = 1'b0;
`endif

   // Global stall: the whole pipe freezes while a result waits at the output.
   assign advance   = !v_q[STAGES-1] || out_ready;
   assign in_ready  = advance;
   assign out_valid = v_q[STAGES-1];
   assign y         = y_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

   always_comb begin
      cur_a   = a;
      cur_b   = sub ? ~b : b;
      cur_s   = '0;
      cur_c   = sub;
      cur_v   = in_valid && advance;
      cur_sat = sat_in;
      csum    = '0;
      for (int k = 0; k < STAGES; k++) begin
         csum = {1'b0, cur_a[k*CHUNK +: CHUNK]} + {1'b0, cur_b[k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, cur_c};
         s_d[k]                   = cur_s;
         s_d[k][k*CHUNK +: CHUNK] = csum[CHUNK-1:0];
         c_d[k]   = csum[CHUNK];
         a_d[k]   = cur_a;
         b_d[k]   = cur_b;
         v_d[k]   = cur_v;
         sat_d[k] = cur_sat;
         // Stage k+1 works from what stage k registered last cycle.
         if (k < STAGES-1) begin
            cur_a   = a_q[k];
            cur_b   = b_q[k];
            cur_s   = s_q[k];
            cur_c   = c_q[k];
            cur_v   = v_q[k];
            cur_sat = sat_q[k];
         end
      end
      // cur_a/cur_b now hold the final stage's operands (B already inverted for sub).
      ovf_d  = (cur_a[WIDTH-1] == cur_b[WIDTH-1]) && (s_d[STAGES-1][WIDTH-1] != cur_a[WIDTH-1]);
      cout_d = c_d[STAGES-1];
      y_d    = s_d[STAGES-1];
      if (cur_sat && ovf_d) begin
         y_d = cur_a[WIDTH-1] ? NEG_MIN : POS_MAX;
      end
      zero_d = (y_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k]   <= 1'b0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            s_q[k]   <= '0;
            c_q[k]   <= 1'b0;
            sat_q[k] <= 1'b0;
         end
         y_q    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k]   <= v_d[k];
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            s_q[k]   <= s_d[k];
            c_q[k]   <= c_d[k];
            sat_q[k] <= sat_d[k];
         end
         y_q    <= y_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe: 4-stage main instance plus 1- and 8-stage instances fed the same beats.
// Saturation vectors run only when ADD_PIPE_SAT_EN is defined.
module tb_add_pipe;

   typedef struct {
      logic [31:0] y;
      logic        c;
      logic        o;
      logic        z;
      int          acc;
      bit          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_valid_x;
   logic [31:0] a = '0, b = '0;
   logic        sub = 1'b0;
   logic        sat = 1'b0;
   logic        out_ready = 1'b1;

   logic        in_ready, rdy1, rdy8;
   logic        ov4, ov1, ov8;
   logic [31:0] y4, y1, y8;
   logic        c4, c1, c8, o4, o1, o8, z4, z1, z8;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t q4[$], q1[$], q8[$];
   exp_t e4, e1, e8;

   localparam logic [31:0] VA [8] = '{32'h12345678, 32'hDEADBEEF, 32'h00000010, 32'h80000000,
                                      32'h7FFFFFFF, 32'hCAFEBABE, 32'h0F0F0F0F, 32'h00010000};
   localparam logic [31:0] VB [8] = '{32'h0FEDCBA9, 32'h21524111, 32'h00000020, 32'h80000000,
                                      32'hFFFFFFFF, 32'h0000FFFF, 32'hF0F0F0F1, 32'h0000FFFF};
   localparam logic [7:0]  VS = 8'b1011_0100;

   assign in_valid_x = in_valid && in_ready;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   add_pipe #(.WIDTH(32), .STAGES(4)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub),
`ifdef ADD_PIPE_SAT_EN
      .sat(sat),
`endif
      .out_valid(ov4), .out_ready(out_ready), .y(y4), .cout(c4), .ovf(o4), .zero(z4));

   add_pipe #(.WIDTH(32), .STAGES(1)) u_s1 (
      .clk(clk), .reset(reset), .in_valid(in_valid_x), .in_ready(rdy1),
      .a(a), .b(b), .sub(sub),
`ifdef ADD_PIPE_SAT_EN
      .sat(sat),
`endif
      .out_valid(ov1), .out_ready(1'b1), .y(y1), .cout(c1), .ovf(o1), .zero(z1));

   add_pipe #(.WIDTH(32), .STAGES(8)) u_s8 (
      .clk(clk), .reset(reset), .in_valid(in_valid_x), .in_ready(rdy8),
      .a(a), .b(b), .sub(sub),
`ifdef ADD_PIPE_SAT_EN
      .sat(sat),
`endif
      .out_valid(ov8), .out_ready(1'b1), .y(y8), .cout(c8), .ovf(o8), .zero(z8));

   task automatic cmp(input string nm, input exp_t e, input logic [31:0] ya, input logic ca,
                      input logic oa, input logic za, input int lat_a, input int lat_r,
                      input bit do_lat);
      checks++;
      if ({ya, ca, oa, za} !== {e.y, e.c, e.o, e.z}) begin
         errors++;
         $display("FAIL %s result: got y=%h cout=%b ovf=%b zero=%b, expected y=%h cout=%b ovf=%b zero=%b",
                  nm, ya, ca, oa, za, e.y, e.c, e.o, e.z);
      end else begin
         $display("%s beat: y=%h cout=%b ovf=%b zero=%b latency=%0d", nm, ya, ca, oa, za, lat_a);
      end
      if (do_lat) begin
         checks++;
         if (lat_a != lat_r) begin
            errors++;
            $display("FAIL %s latency: got %0d, expected %0d", nm, lat_a, lat_r);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset && ov4 && out_ready) begin
         if (q4.size() == 0) begin
            checks++; errors++;
            $display("FAIL main unexpected beat: got y=%h, expected no output", y4);
         end else begin
            e4 = q4.pop_front();
            cmp("main", e4, y4, c4, o4, z4, cyc - e4.acc, 4, e4.lat);
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && ov1) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL s1 unexpected beat: got y=%h, expected no output", y1);
         end else begin
            e1 = q1.pop_front();
            cmp("s1", e1, y1, c1, o1, z1, cyc - e1.acc, 1, 1'b1);
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && ov8) begin
         if (q8.size() == 0) begin
            checks++; errors++;
            $display("FAIL s8 unexpected beat: got y=%h, expected no output", y8);
         end else begin
            e8 = q8.pop_front();
            cmp("s8", e8, y8, c8, o8, z8, cyc - e8.acc, 8, 1'b1);
         end
      end
   end

   task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic sv, input logic satv,
                       input logic [31:0] ey, input logic ec, input logic eo, input logic ez,
                       input bit lat);
      exp_t e;
      int   n;
      a = av; b = bv; sub = sv; sat = satv; in_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n >= 40) break;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send: in_ready=0 for %0d cycles, expected 1", n);
      end else begin
         e = '{y: ey, c: ec, o: eo, z: ez, acc: cyc, lat: lat};
         q4.push_back(e); q1.push_back(e); q8.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Reference: 64-bit signed arithmetic for y/ovf, unsigned compare for carry/borrow.
   task automatic send_m(input logic [31:0] av, input logic [31:0] bv, input logic sv);
      longint      r;
      logic [63:0] u;
      logic [31:0] ey;
      logic        ec, eo;
      r  = sv ? (longint'($signed(av)) - longint'($signed(bv)))
              : (longint'($signed(av)) + longint'($signed(bv)));
      u  = r;
      ey = u[31:0];
      eo = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      if (sv) ec = (av >= bv);
      else    ec = (({32'b0, av} + {32'b0, bv}) > 64'h0000_0000_FFFF_FFFF);
      send(av, bv, sv, 1'b0, ey, ec, eo, (ey == 32'h0), 1'b0);
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while ((q4.size() + q1.size() + q8.size()) != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if ((q4.size() + q1.size() + q8.size()) != 0) begin
         errors++;
         $display("FAIL %s drain: got %0d beats outstanding, expected 0", nm,
                  q4.size() + q1.size() + q8.size());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ys;
      logic        cs, os, zs;

      // Reset held two cycles
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ov4, y4, c4, o4, z4, ov1, ov8} !== '0) begin
         errors++;
         $display("FAIL reset state: got out_valid=%b y=%h cout=%b ovf=%b zero=%b, expected all 0",
                  ov4, y4, c4, o4, z4);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL in_ready after reset: got %b, expected 1", in_ready);
      end
      @(posedge clk); #1;

      // Carry ripples across three chunk boundaries; latency checked
      send(32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b1);
      drain("carry");

      // Flag corners
      send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
      send(32'h0,         32'h1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
      send(32'h5,         32'h5, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0);
      send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0);
      send(32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
      drain("flags");

      // Eight back-to-back beats with a 3-cycle output stall mid-stream
      fork
         begin
            for (int i = 0; i < 8; i++) send_m(VA[i], VB[i], VS[7-i]);
         end
         begin
            repeat (6) @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            ys = y4; cs = c4; os = o4; zs = z4;
            for (int i = 0; i < 3; i++) begin
               if (i > 0) @(negedge clk);
               checks++;
               if (in_ready !== 1'b0 || ov4 !== 1'b1 || {y4, c4, o4, z4} !== {ys, cs, os, zs}) begin
                  errors++;
                  $display("FAIL stall cycle %0d: got in_ready=%b out_valid=%b y=%h, expected 0 1 %h",
                           i, in_ready, ov4, y4, ys);
               end
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain("stream");

      // Reset with three beats in flight: nothing may emerge afterwards
      send_m(32'h1111_1111, 32'h2222_2222, 1'b0);
      send_m(32'h3333_3333, 32'h1111_1111, 1'b1);
      send_m(32'h0000_0042, 32'h0000_0001, 1'b0);
      reset = 1'b1;
      q4.delete(); q1.delete(); q8.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({ov4, ov1, ov8} !== 3'b000) begin
            errors++;
            $display("FAIL post-reset cycle %0d: got out_valid main/s1/s8=%b%b%b, expected 000",
                     i, ov4, ov1, ov8);
         end
      end
      @(posedge clk); #1;

      // Fresh beat after reset, latency checked again
      send(32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b1);
      drain("after reset");

`ifdef ADD_PIPE_SAT_EN
      send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
      send(32'h8000_0000, 32'h1, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
      send(32'h0000_0003, 32'h4, 1'b0, 1'b1, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b0);
      send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
      drain("sat");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
